// File: rtl/argmax_stream.sv
// Streaming argmax over one float32 vector per AXI4-Stream packet.
// Emits a two-word result packet: winning index, then winning value.
module argmax_stream #(
  parameter int unsigned IDX_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY
);

  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    RECV     = 2'd0,
    SEND_IDX = 2'd1,
    SEND_MAX = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                first;
  logic [IDX_W-1:0]    cnt;
  logic [DATA_W-1:0]   best_val;
  logic [IDX_W-1:0]    best_idx;

  logic                accept;
  logic                out_hs;
  logic                take;
  logic [DATA_W-1:0]   cand_val;
  logic [IDX_W-1:0]    cand_idx;

  logic [DATA_W-1:0]   out_data_d;
  logic                out_last_d;
  logic                out_valid_d;

  // Maps float bits onto an unsigned total order (-NaN lowest, +NaN highest).
  function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] f);
    return f[DATA_W-1] ? ~f : (f ^ 32'h8000_0000);
  endfunction

  assign INPUT_AXIS_TREADY = (state == RECV) && !rst;

  assign accept   = INPUT_AXIS_TVALID && (state == RECV);
  assign out_hs   = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;
  assign take     = accept &&
                    (first || (order_key(INPUT_AXIS_TDATA) > order_key(best_val)));
  assign cand_val = take ? INPUT_AXIS_TDATA : best_val;
  assign cand_idx = take ? (first ? '0 : cnt) : best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RECV;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RECV:     if (accept && INPUT_AXIS_TLAST) state_next = SEND_IDX;
      SEND_IDX: if (out_hs) state_next = SEND_MAX;
      SEND_MAX: if (out_hs) state_next = RECV;
      default:  state_next = RECV;
    endcase
  end

  // Next values for the registered output word; hold unless an event moves them.
  always_comb begin
    out_valid_d = OUTPUT_AXIS_TVALID;
    out_data_d  = OUTPUT_AXIS_TDATA;
    out_last_d  = OUTPUT_AXIS_TLAST;
    case (state)
      RECV: begin
        if (accept && INPUT_AXIS_TLAST) begin
          out_valid_d = 1'b1;
          out_data_d  = DATA_W'(cand_idx);
          out_last_d  = 1'b0;
        end else begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_last_d  = 1'b0;
        end
      end
      SEND_IDX: begin
        if (out_hs) begin
          out_valid_d = 1'b1;
          out_data_d  = best_val;
          out_last_d  = 1'b1;
        end
      end
      SEND_MAX: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_last_d  = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUTPUT_AXIS_TVALID <= 1'b0;
      OUTPUT_AXIS_TDATA  <= '0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
    end else begin
      OUTPUT_AXIS_TVALID <= out_valid_d;
      OUTPUT_AXIS_TDATA  <= out_data_d;
      OUTPUT_AXIS_TLAST  <= out_last_d;
    end
  end

  // Running best and saturating element counter; rearmed once the result drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= 1'b1;
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (accept) begin
      first    <= 1'b0;
      best_val <= cand_val;
      best_idx <= cand_idx;
      cnt      <= (cnt == IDX_MAX) ? cnt : cnt + IDX_W'(1);
    end else if ((state == SEND_MAX) && out_hs) begin
      first <= 1'b1;
      cnt   <= '0;
    end
  end

endmodule
